// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle MIPS controller and its datapath/memory.
// The controller drives the master side; datapath and memory sit on the slave side.
interface multicycle_control_if #(
    parameter int ALUOP_W = 4
);
    logic [5:0]         Opcode;
    logic [5:0]         Funct;
    logic               Zero;
    logic               MemReady;
    logic               MemReq;
    logic               MemWe;
    logic               IorD;
    logic               IRWrite;
    logic               PCWrite;
    logic [1:0]         PCSrc;
    logic [1:0]         ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic               ExtFormat;
    logic [ALUOP_W-1:0] ALUOp;
    logic               RegDst;
    logic               Jal;
    logic               MemtoReg;
    logic               RegWrite;
    logic               Trap;
    logic [1:0]         TrapCause;
    logic [2:0]         State;

    modport master (
        input  Opcode, Funct, Zero, MemReady,
        output MemReq, MemWe, IorD, IRWrite, PCWrite, PCSrc, ALUSrcA, ALUSrcB,
               ExtFormat, ALUOp, RegDst, Jal, MemtoReg, RegWrite, Trap, TrapCause, State
    );

    modport slave (
        output Opcode, Funct, Zero, MemReady,
        input  MemReq, MemWe, IorD, IRWrite, PCWrite, PCSrc, ALUSrcA, ALUSrcB,
               ExtFormat, ALUOp, RegDst, Jal, MemtoReg, RegWrite, Trap, TrapCause, State
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB/BRANCH/JUMP with
// illegal-instruction and memory-timeout trapping into a sticky TRAP state.
module multicycle_control #(
    parameter int ALUOP_W    = 4,
    parameter int WAIT_LIMIT = 15
) (
    input logic                 Clk,
    input logic                 Reset_n,
    multicycle_control_if.master bus
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        BRANCH = 3'd5,
        JUMP   = 3'd6,
        TRAP   = 3'd7
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03,
                           OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08,
                           OP_SLTI  = 6'h0A, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D,
                           OP_XORI  = 6'h0E, OP_LUI  = 6'h0F, OP_LW   = 6'h23,
                           OP_SW    = 6'h2B;
    localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03,
                           FN_JR  = 6'h08, FN_ADD = 6'h20, FN_SUB = 6'h22,
                           FN_AND = 6'h24, FN_OR  = 6'h25, FN_XOR = 6'h26,
                           FN_SLT = 6'h2A;
    localparam logic [3:0] ALU_AND = 4'h0, ALU_OR  = 4'h1, ALU_ADD = 4'h2,
                           ALU_XOR = 4'h3, ALU_SLL = 4'h4, ALU_SRL = 4'h5,
                           ALU_SUB = 4'h6, ALU_SLT = 4'h7, ALU_LUI = 4'h8,
                           ALU_SRA = 4'h9;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1, CAUSE_TIMEOUT = 2'd2;
    localparam int CNT_W = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);

    state_t           state_q, state_d;
    logic [1:0]       cause_q, cause_d;
    logic [CNT_W-1:0] wait_q, wait_d;

    logic is_rtype, is_lw, is_sw, is_beq, is_bne, is_jal, is_jr, is_jump, is_shift;
    logic exec_legal, sign_ext, timeout;
    logic [3:0] exec_op;

    logic       mem_req, mem_we, iord, ir_write, pc_write, ext_format;
    logic       reg_dst, jal, memtoreg, reg_write, trap;
    logic [1:0] pc_src, alu_src_a, alu_src_b;
    logic [3:0] alu_op;

    always_comb begin
        is_rtype = (bus.Opcode == OP_RTYPE);
        is_lw    = (bus.Opcode == OP_LW);
        is_sw    = (bus.Opcode == OP_SW);
        is_beq   = (bus.Opcode == OP_BEQ);
        is_bne   = (bus.Opcode == OP_BNE);
        is_jal   = (bus.Opcode == OP_JAL);
        is_jr    = is_rtype && (bus.Funct == FN_JR);
        is_jump  = (bus.Opcode == OP_J) || is_jal || is_jr;
        is_shift = is_rtype && (bus.Funct == FN_SLL || bus.Funct == FN_SRL || bus.Funct == FN_SRA);
        sign_ext = (bus.Opcode == OP_ADDI) || (bus.Opcode == OP_SLTI) || is_lw || is_sw;
        exec_legal = 1'b1;
        exec_op    = ALU_ADD;
        case (bus.Opcode)
            OP_RTYPE: begin
                case (bus.Funct)
                    FN_ADD:  exec_op = ALU_ADD;
                    FN_SUB:  exec_op = ALU_SUB;
                    FN_AND:  exec_op = ALU_AND;
                    FN_OR:   exec_op = ALU_OR;
                    FN_XOR:  exec_op = ALU_XOR;
                    FN_SLT:  exec_op = ALU_SLT;
                    FN_SLL:  exec_op = ALU_SLL;
                    FN_SRL:  exec_op = ALU_SRL;
                    FN_SRA:  exec_op = ALU_SRA;
                    default: exec_legal = 1'b0;
                endcase
            end
            OP_ADDI:     exec_op = ALU_ADD;
            OP_SLTI:     exec_op = ALU_SLT;
            OP_ANDI:     exec_op = ALU_AND;
            OP_ORI:      exec_op = ALU_OR;
            OP_XORI:     exec_op = ALU_XOR;
            OP_LUI:      exec_op = ALU_LUI;
            OP_LW, OP_SW: exec_op = ALU_ADD;
            default:     exec_legal = 1'b0;
        endcase
    end

    // Counter holds the number of MemReady-low cycles already spent on this request.
    assign timeout = (WAIT_LIMIT != 0) && (wait_q == CNT_W'(WAIT_LIMIT));

    // Handshake: MemReq is held high until a cycle with MemReady=1, which
    // completes the access; MemReady is ignored whenever MemReq is low.
    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'd0;
        alu_src_a  = 2'd0;
        alu_src_b  = 2'd0;
        ext_format = 1'b0;
        alu_op     = ALU_ADD;
        reg_dst    = 1'b0;
        jal        = 1'b0;
        memtoreg   = 1'b0;
        reg_write  = 1'b0;
        trap       = 1'b0;
        if (Reset_n) begin
            case (state_q)
                FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = 2'd1;
                    if (bus.MemReady) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = DECODE;
                    end else if (timeout) begin
                        state_d = TRAP;
                        cause_d = CAUSE_TIMEOUT;
                    end
                end
                DECODE: begin
                    alu_src_b  = 2'd3;
                    ext_format = 1'b1;
                    if (is_beq || is_bne)  state_d = BRANCH;
                    else if (is_jump)      state_d = JUMP;
                    else if (exec_legal)   state_d = EXEC;
                    else begin
                        state_d = TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end
                end
                EXEC: begin
                    alu_src_a  = is_shift ? 2'd2 : 2'd1;
                    alu_src_b  = is_rtype ? 2'd0 : 2'd2;
                    ext_format = sign_ext;
                    alu_op     = exec_op;
                    state_d    = (is_lw || is_sw) ? MEM : WB;
                end
                MEM: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    mem_we  = is_sw;
                    if (bus.MemReady) begin
                        state_d = is_lw ? WB : FETCH;
                    end else if (timeout) begin
                        state_d = TRAP;
                        cause_d = CAUSE_TIMEOUT;
                    end
                end
                WB: begin
                    reg_write = 1'b1;
                    reg_dst   = !is_rtype;
                    memtoreg  = is_lw;
                    state_d   = FETCH;
                end
                BRANCH: begin
                    alu_src_a = 2'd1;
                    alu_src_b = 2'd0;
                    alu_op    = ALU_SUB;
                    pc_src    = 2'd1;
                    pc_write  = (is_beq && bus.Zero) || (is_bne && !bus.Zero);
                    state_d   = FETCH;
                end
                JUMP: begin
                    pc_write  = 1'b1;
                    pc_src    = is_jr ? 2'd2 : 2'd3;
                    jal       = is_jal;
                    reg_write = is_jal;
                    state_d   = FETCH;
                end
                default: trap = 1'b1;
            endcase
        end
        wait_d = (mem_req && !bus.MemReady && state_d == state_q) ? wait_q + CNT_W'(1) : '0;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= FETCH;
            cause_q <= 2'd0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            wait_q  <= wait_d;
        end
    end

    assign bus.MemReq    = mem_req;
    assign bus.MemWe     = mem_we;
    assign bus.IorD      = iord;
    assign bus.IRWrite   = ir_write;
    assign bus.PCWrite   = pc_write;
    assign bus.PCSrc     = pc_src;
    assign bus.ALUSrcA   = alu_src_a;
    assign bus.ALUSrcB   = alu_src_b;
    assign bus.ExtFormat = ext_format;
    assign bus.ALUOp     = ALUOP_W'(alu_op);
    assign bus.RegDst    = reg_dst;
    assign bus.Jal       = jal;
    assign bus.MemtoReg  = memtoreg;
    assign bus.RegWrite  = reg_write;
    assign bus.Trap      = trap;
    assign bus.TrapCause = cause_q;
    assign bus.State     = state_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: instruction sequencing, handshake waits,
// branch/jump control, illegal-instruction and memory-timeout traps, reset behaviour.
module tb_multicycle_control;
    localparam int ALUOP_W    = 4;
    localparam int WAIT_LIMIT = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    logic [2:0] exp_q[$];

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] fn;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic       ext;
        logic [3:0] alu;
        logic       rd;
    } alu_vec_t;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic       zero;
        logic       pcw;
    } br_vec_t;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] fn;
        logic [1:0] pcsrc;
        logic       jal;
    } jmp_vec_t;

    alu_vec_t alu_tab[$];
    br_vec_t  br_tab[$];
    jmp_vec_t jmp_tab[$];

    multicycle_control_if #(.ALUOP_W(ALUOP_W)) bus ();

    multicycle_control #(.ALUOP_W(ALUOP_W), .WAIT_LIMIT(WAIT_LIMIT)) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [5:0] fn);
        bus.Opcode   = op;
        bus.Funct    = fn;
        bus.MemReady = 1'b1;
        #1;
    endtask

    task automatic check_fetch(input string tag);
        check({tag, ":f_state"}, 32'(bus.State), 0);
        check({tag, ":f_memreq"}, 32'(bus.MemReq), 1);
        check({tag, ":f_irwrite"}, 32'(bus.IRWrite), 1);
        check({tag, ":f_pcwrite"}, 32'(bus.PCWrite), 1);
        check({tag, ":f_srcb"}, 32'(bus.ALUSrcB), 1);
    endtask

    task automatic run_alu(input alu_vec_t v);
        set_instr(v.op, v.fn);
        check_fetch(v.name);
        tick();
        check({v.name, ":d_state"}, 32'(bus.State), 1);
        check({v.name, ":d_srcb"}, 32'(bus.ALUSrcB), 3);
        check({v.name, ":d_ext"}, 32'(bus.ExtFormat), 1);
        tick();
        check({v.name, ":e_state"}, 32'(bus.State), 2);
        check({v.name, ":e_srca"}, 32'(bus.ALUSrcA), 32'(v.src_a));
        check({v.name, ":e_srcb"}, 32'(bus.ALUSrcB), 32'(v.src_b));
        check({v.name, ":e_ext"}, 32'(bus.ExtFormat), 32'(v.ext));
        check({v.name, ":e_aluop"}, 32'(bus.ALUOp), 32'(v.alu));
        check({v.name, ":e_regwrite"}, 32'(bus.RegWrite), 0);
        tick();
        check({v.name, ":w_state"}, 32'(bus.State), 4);
        check({v.name, ":w_regwrite"}, 32'(bus.RegWrite), 1);
        check({v.name, ":w_regdst"}, 32'(bus.RegDst), 32'(v.rd));
        check({v.name, ":w_memtoreg"}, 32'(bus.MemtoReg), 0);
        tick();
    endtask

    task automatic reset_pulse(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, ":rst_state"}, 32'(bus.State), 0);
        check({tag, ":rst_trap"}, 32'(bus.Trap), 0);
        check({tag, ":rst_cause"}, 32'(bus.TrapCause), 0);
        check({tag, ":rst_memreq"}, 32'(bus.MemReq), 0);
        check({tag, ":rst_regwrite"}, 32'(bus.RegWrite), 0);
        check({tag, ":rst_pcwrite"}, 32'(bus.PCWrite), 0);
        tick();
        rst_n = 1'b1;
        #1;
        check({tag, ":rel_memreq"}, 32'(bus.MemReq), 1);
    endtask

    initial begin
        alu_tab.push_back('{"add",  6'h00, 6'h20, 2'd1, 2'd0, 1'b0, 4'h2, 1'b0});
        alu_tab.push_back('{"sub",  6'h00, 6'h22, 2'd1, 2'd0, 1'b0, 4'h6, 1'b0});
        alu_tab.push_back('{"and",  6'h00, 6'h24, 2'd1, 2'd0, 1'b0, 4'h0, 1'b0});
        alu_tab.push_back('{"or",   6'h00, 6'h25, 2'd1, 2'd0, 1'b0, 4'h1, 1'b0});
        alu_tab.push_back('{"xor",  6'h00, 6'h26, 2'd1, 2'd0, 1'b0, 4'h3, 1'b0});
        alu_tab.push_back('{"slt",  6'h00, 6'h2A, 2'd1, 2'd0, 1'b0, 4'h7, 1'b0});
        alu_tab.push_back('{"sll",  6'h00, 6'h00, 2'd2, 2'd0, 1'b0, 4'h4, 1'b0});
        alu_tab.push_back('{"srl",  6'h00, 6'h02, 2'd2, 2'd0, 1'b0, 4'h5, 1'b0});
        alu_tab.push_back('{"sra",  6'h00, 6'h03, 2'd2, 2'd0, 1'b0, 4'h9, 1'b0});
        alu_tab.push_back('{"addi", 6'h08, 6'h00, 2'd1, 2'd2, 1'b1, 4'h2, 1'b1});
        alu_tab.push_back('{"slti", 6'h0A, 6'h00, 2'd1, 2'd2, 1'b1, 4'h7, 1'b1});
        alu_tab.push_back('{"andi", 6'h0C, 6'h00, 2'd1, 2'd2, 1'b0, 4'h0, 1'b1});
        alu_tab.push_back('{"ori",  6'h0D, 6'h00, 2'd1, 2'd2, 1'b0, 4'h1, 1'b1});
        alu_tab.push_back('{"xori", 6'h0E, 6'h00, 2'd1, 2'd2, 1'b0, 4'h3, 1'b1});
        alu_tab.push_back('{"lui",  6'h0F, 6'h00, 2'd1, 2'd2, 1'b0, 4'h8, 1'b1});

        br_tab.push_back('{"beq_z1", 6'h04, 1'b1, 1'b1});
        br_tab.push_back('{"beq_z0", 6'h04, 1'b0, 1'b0});
        br_tab.push_back('{"bne_z1", 6'h05, 1'b1, 1'b0});
        br_tab.push_back('{"bne_z0", 6'h05, 1'b0, 1'b1});

        jmp_tab.push_back('{"j",   6'h02, 6'h00, 2'd3, 1'b0});
        jmp_tab.push_back('{"jal", 6'h03, 6'h00, 2'd3, 1'b1});
        jmp_tab.push_back('{"jr",  6'h00, 6'h08, 2'd2, 1'b0});

        // Reset state
        bus.Opcode   = 6'h00;
        bus.Funct    = 6'h20;
        bus.Zero     = 1'b0;
        bus.MemReady = 1'b1;
        rst_n        = 1'b0;
        #1;
        check("reset:state", 32'(bus.State), 0);
        check("reset:memreq", 32'(bus.MemReq), 0);
        check("reset:irwrite", 32'(bus.IRWrite), 0);
        check("reset:pcwrite", 32'(bus.PCWrite), 0);
        check("reset:aluop", 32'(bus.ALUOp), 2);
        check("reset:srcb", 32'(bus.ALUSrcB), 0);
        check("reset:trap", 32'(bus.Trap), 0);
        check("reset:cause", 32'(bus.TrapCause), 0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;

        // ALU-class instructions
        foreach (alu_tab[i]) run_alu(alu_tab[i]);

        // lw with three MemReady-low cycles in MEM: 8 cycles total
        set_instr(6'h23, 6'h00);
        exp_q = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
        for (int c = 0; c < 8; c++) begin
            logic [2:0] e;
            e = exp_q.pop_front();
            bus.MemReady = (c >= 3 && c <= 5) ? 1'b0 : 1'b1;
            #1;
            check($sformatf("lw:state_c%0d", c), 32'(bus.State), 32'(e));
            if (e == 3'd3) begin
                check($sformatf("lw:memreq_c%0d", c), 32'(bus.MemReq), 1);
                check($sformatf("lw:iord_c%0d", c), 32'(bus.IorD), 1);
                check($sformatf("lw:memwe_c%0d", c), 32'(bus.MemWe), 0);
                check($sformatf("lw:regwrite_c%0d", c), 32'(bus.RegWrite), 0);
            end
            if (e == 3'd2) begin
                check("lw:e_srcb", 32'(bus.ALUSrcB), 2);
                check("lw:e_ext", 32'(bus.ExtFormat), 1);
                check("lw:e_aluop", 32'(bus.ALUOp), 2);
            end
            if (e == 3'd4) begin
                check("lw:w_regwrite", 32'(bus.RegWrite), 1);
                check("lw:w_memtoreg", 32'(bus.MemtoReg), 1);
                check("lw:w_regdst", 32'(bus.RegDst), 1);
            end
            tick();
        end
        #1;
        check("lw:done_state", 32'(bus.State), 0);

        // sw: 4 cycles, write request in MEM
        set_instr(6'h2B, 6'h00);
        check_fetch("sw");
        tick();
        tick();
        check("sw:e_state", 32'(bus.State), 2);
        check("sw:e_ext", 32'(bus.ExtFormat), 1);
        tick();
        check("sw:m_state", 32'(bus.State), 3);
        check("sw:m_memwe", 32'(bus.MemWe), 1);
        check("sw:m_iord", 32'(bus.IorD), 1);
        check("sw:m_regwrite", 32'(bus.RegWrite), 0);
        tick();
        check("sw:done_state", 32'(bus.State), 0);

        // Branches
        foreach (br_tab[i]) begin
            set_instr(br_tab[i].op, 6'h00);
            bus.Zero = br_tab[i].zero;
            #1;
            check_fetch(br_tab[i].name);
            tick();
            check({br_tab[i].name, ":d_state"}, 32'(bus.State), 1);
            tick();
            check({br_tab[i].name, ":b_state"}, 32'(bus.State), 5);
            check({br_tab[i].name, ":b_pcwrite"}, 32'(bus.PCWrite), 32'(br_tab[i].pcw));
            check({br_tab[i].name, ":b_pcsrc"}, 32'(bus.PCSrc), 1);
            check({br_tab[i].name, ":b_aluop"}, 32'(bus.ALUOp), 6);
            check({br_tab[i].name, ":b_srca"}, 32'(bus.ALUSrcA), 1);
            tick();
            check({br_tab[i].name, ":done_state"}, 32'(bus.State), 0);
        end
        bus.Zero = 1'b0;

        // Jumps
        foreach (jmp_tab[i]) begin
            set_instr(jmp_tab[i].op, jmp_tab[i].fn);
            check_fetch(jmp_tab[i].name);
            tick();
            check({jmp_tab[i].name, ":d_state"}, 32'(bus.State), 1);
            tick();
            check({jmp_tab[i].name, ":j_state"}, 32'(bus.State), 6);
            check({jmp_tab[i].name, ":j_pcwrite"}, 32'(bus.PCWrite), 1);
            check({jmp_tab[i].name, ":j_pcsrc"}, 32'(bus.PCSrc), 32'(jmp_tab[i].pcsrc));
            check({jmp_tab[i].name, ":j_jal"}, 32'(bus.Jal), 32'(jmp_tab[i].jal));
            check({jmp_tab[i].name, ":j_regwrite"}, 32'(bus.RegWrite), 32'(jmp_tab[i].jal));
            tick();
            check({jmp_tab[i].name, ":done_state"}, 32'(bus.State), 0);
        end

        // Reset mid-instruction (lw in EXEC) aborts it
        set_instr(6'h23, 6'h00);
        tick();
        tick();
        check("abort:e_state", 32'(bus.State), 2);
        reset_pulse("abort");

        // MemReady arriving exactly at the wait limit completes the fetch
        set_instr(6'h00, 6'h20);
        bus.MemReady = 1'b0;
        #1;
        for (int c = 0; c < WAIT_LIMIT; c++) begin
            check($sformatf("edge:state_c%0d", c), 32'(bus.State), 0);
            check($sformatf("edge:irwrite_c%0d", c), 32'(bus.IRWrite), 0);
            tick();
        end
        bus.MemReady = 1'b1;
        #1;
        check("edge:limit_state", 32'(bus.State), 0);
        check("edge:limit_irwrite", 32'(bus.IRWrite), 1);
        tick();
        check("edge:decode", 32'(bus.State), 1);
        tick();
        tick();
        tick();
        check("edge:done_state", 32'(bus.State), 0);

        // MemReady stuck low: trap after WAIT_LIMIT wait cycles
        bus.MemReady = 1'b0;
        #1;
        for (int c = 0; c <= WAIT_LIMIT; c++) begin
            check($sformatf("tmo:state_c%0d", c), 32'(bus.State), 0);
            tick();
        end
        check("tmo:state", 32'(bus.State), 7);
        check("tmo:trap", 32'(bus.Trap), 1);
        check("tmo:cause", 32'(bus.TrapCause), 2);
        check("tmo:memreq", 32'(bus.MemReq), 0);
        bus.MemReady = 1'b1;
        reset_pulse("tmo");

        // Illegal opcode: TRAP after DECODE, held until reset
        set_instr(6'h3F, 6'h00);
        check_fetch("ill");
        tick();
        check("ill:d_state", 32'(bus.State), 1);
        tick();
        for (int c = 0; c < 20; c++) begin
            check($sformatf("ill:state_c%0d", c), 32'(bus.State), 7);
            check($sformatf("ill:trap_c%0d", c), 32'(bus.Trap), 1);
            check($sformatf("ill:cause_c%0d", c), 32'(bus.TrapCause), 1);
            check($sformatf("ill:en_c%0d", c),
                  32'({bus.MemReq, bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWe}), 0);
            tick();
        end
        reset_pulse("ill");

        // Normal operation resumes after trap reset
        run_alu(alu_tab[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multi-cycle successor to the single-cycle MIPS control decoder. A Moore/Mealy FSM sequences each instruction through FETCH/DECODE/EXEC/MEM/WB over a shared memory port with a request/ready handshake. It drives the multi-cycle datapath (IR, A/B, ALUOut, MDR registers) and adds illegal-instruction and memory-timeout trapping. The supported instruction set is unchanged: add/addi, sub, and/andi, or/ori, xor/xori, slt/slti, sll, srl, sra, lui, lw, sw, beq, bne, j, jal, jr.

Parameters:
ALUOP_W, 4, ALUOp width; encodings occupy the low 4 bits, upper bits are 0.
WAIT_LIMIT, 15, maximum cycles MemReq may wait for MemReady before trapping; 0 disables the timeout.

Ports:
Clk  in  1  clock; all state changes on the rising edge.
Reset_n  in  1  asynchronous, active-low reset.
Opcode  in  6  IR[31:26] (IR register output).
Funct  in  6  IR[5:0].
Zero  in  1  ALU zero flag.
MemReady  in  1  memory completes the current request this cycle.
MemReq  out  1  memory access request.
MemWe  out  1  the request is a write (sw).
IorD  out  1  address select: 0 = PC, 1 = ALUOut.
IRWrite  out  1  load IR from memory data.
PCWrite  out  1  load PC from the PCSrc mux.
PCSrc  out  2  0 = ALU result, 1 = ALUOut (branch target), 2 = A (jr), 3 = {PC[31:28], addr, 00}.
ALUSrcA  out  2  0 = PC, 1 = A, 2 = shamt.
ALUSrcB  out  2  0 = B, 1 = const 4, 2 = ext imm, 3 = ext imm << 2.
ExtFormat  out  1  1 = sign-extend, 0 = zero-extend.
ALUOp  out  ALUOP_W  ALU operation.
RegDst  out  1  0 = rd, 1 = rt.
Jal  out  1  force $31 as destination; write data = PC.
MemtoReg  out  1  write data from MDR.
RegWrite  out  1  register file write enable.
Trap  out  1  sticky: FSM halted in TRAP.
TrapCause  out  2  0 = none, 1 = illegal instruction, 2 = memory timeout.
State  out  3  current state, for debug.

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, BRANCH=5, JUMP=6, TRAP=7.
- Reset:
  - Reset_n low forces State=FETCH, wait counter=0, Trap=0, TrapCause=0.
  - While reset is asserted, MemReq, PCWrite, IRWrite, RegWrite and MemWe are all forced 0.
  - All other outputs are the defaults listed below.
  - The first MemReq rises in the first cycle after release.
  - Reset asserted mid-instruction aborts it immediately; no write enable may glitch high.
- Output defaults (apply in every state unless stated otherwise): all outputs 0, except ALUOp=add.
- ALUOp encodings:
  - and 0000, or 0001, add 0010, xor 0011, sll 0100, srl 0101, sub 0110, slt 0111, lui 1000, sra 1001.
  - lw/sw use add; beq/bne use sub.
- FETCH:
  - Outputs: MemReq=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=add, PCSrc=0.
  - Hold until MemReady=1. In that cycle IRWrite=1 and PCWrite=1 (PC <= PC+4), then go to DECODE.
- DECODE:
  - ALUSrcA=0, ALUSrcB=3, ExtFormat=1, ALUOp=add (ALUOut <= branch target).
  - Next state:
    - beq/bne -> BRANCH
    - j/jal/jr -> JUMP
    - legal ALU, lui, lw or sw -> EXEC
    - otherwise -> TRAP with TrapCause=1.
- EXEC:
  - ALUSrcA: 2 for sll/srl/sra, else 1.
  - ALUSrcB: 0 for R-type, else 2.
  - ExtFormat=1 for addi/slti/lw/sw; 0 for andi/ori/xori/lui.
  - ALUOp per instruction.
  - Next state: lw/sw -> MEM; otherwise -> WB.
- MEM:
  - MemReq=1, IorD=1, MemWe=1 for sw.
  - Hold until MemReady. Then lw -> WB (MDR loaded), sw -> FETCH.
- WB:
  - RegWrite=1.
  - RegDst: 0 for R-type, 1 otherwise.
  - MemtoReg=1 for lw.
  - Next state: FETCH.
- BRANCH:
  - ALUSrcA=1, ALUSrcB=0, ALUOp=sub, PCSrc=1.
  - PCWrite = (beq & Zero) | (bne & ~Zero), evaluated combinationally this cycle.
  - Next state: FETCH.
- JUMP:
  - PCWrite=1.
  - PCSrc: 2 for jr, else 3.
  - jal: Jal=1 and RegWrite=1 (writes the already-incremented PC+4 to $31).
  - Next state: FETCH.
- Timeout:
  - The wait counter increments each cycle MemReq=1 and MemReady=0, and clears when MemReady=1 or on leaving the state.
  - If WAIT_LIMIT != 0 and the counter reaches WAIT_LIMIT with MemReady still 0, go to TRAP with TrapCause=2.
  - MemReady arriving in the same cycle the limit is reached wins: the access completes and no trap is taken.
- TRAP: all enables 0, Trap=1. Exit only by reset.
- Latency with zero memory wait: R/I ALU 4 cycles, lw 5, sw 4, branch 3, jump 3. Each MemReady-low cycle adds 1.
- MemReady while MemReq=0 is ignored.

Test Plan:
- Reset release, MemReady=1 every cycle, add (Opcode 00, Funct 20) -> State 0,1,2,4,0; RegWrite=1 only in WB; RegDst=0; ALUOp=0010 in EXEC.
- lw with MemReady low for 3 cycles in MEM -> MEM held 4 cycles; IorD=1, MemWe=0; then WB with MemtoReg=1, RegDst=1; total 8 cycles.
- beq with Zero=1 -> PCWrite=1, PCSrc=1 in BRANCH. bne with Zero=1 -> PCWrite=0. Both return to FETCH after 3 cycles.
- jal -> JUMP with PCSrc=3, Jal=1, RegWrite=1, PCWrite=1. jr (Funct 08) -> PCSrc=2, RegWrite=0.
- Opcode 3F -> TRAP after DECODE, Trap=1, TrapCause=1; holds for 20 cycles; Reset_n pulse -> FETCH, Trap=0.
- WAIT_LIMIT=15, MemReady stuck 0 in FETCH -> TRAP, TrapCause=2 after 15 wait cycles. MemReady=1 exactly at the limit -> no trap, DECODE entered.
